// File: rtl/skin_pkg.sv
// Shared definitions for the Cb/Cr skin mask stage: config address map,
// default skin window and the per-pixel record passed to the filter.
package skin_pkg;

  localparam logic [1:0] ADDR_CB_LO = 2'd0;
  localparam logic [1:0] ADDR_CB_HI = 2'd1;
  localparam logic [1:0] ADDR_CR_LO = 2'd2;
  localparam logic [1:0] ADDR_CR_HI = 2'd3;

  localparam int DEF_CB_LO = 85;
  localparam int DEF_CB_HI = 127;
  localparam int DEF_CR_LO = 132;
  localparam int DEF_CR_HI = 155;

  typedef struct packed {
    logic vld;
    logic mask;
    logic eol;
    logic eof;
  } pix_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/skin_hmaj3.sv
// Horizontal 3-tap majority filter over the classified mask, with edge
// replication, end-of-line flush and a straight bypass path.
module skin_hmaj3
  import skin_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic filt_en,
  input  pix_t in_pix,
  output logic out_vld,
  output logic out_mask,
  output logic out_eof
);

  logic have_cur_q, have_cur_d;
  logic cur_mask_q, cur_mask_d;
  logic cur_eol_q, cur_eol_d;
  logic cur_eof_q, cur_eof_d;
  logic have_prev_q, have_prev_d;
  logic prev_mask_q, prev_mask_d;
  logic o_vld_q, o_vld_d;
  logic o_mask_q, o_mask_d;
  logic o_eof_q, o_eof_d;

  logic emit;
  logic emit_mask;
  logic emit_eof;
  logic left_mask;
  logic right_mask;

  // The held pixel is emitted once its right neighbour arrives, or on its own
  // when it closes the line; missing neighbours replicate the centre pixel.
  always_comb begin
    have_cur_d  = have_cur_q;
    cur_mask_d  = cur_mask_q;
    cur_eol_d   = cur_eol_q;
    cur_eof_d   = cur_eof_q;
    have_prev_d = have_prev_q;
    prev_mask_d = prev_mask_q;
    emit        = 1'b0;
    emit_mask   = 1'b0;
    emit_eof    = 1'b0;
    left_mask   = have_prev_q ? prev_mask_q : cur_mask_q;
    right_mask  = (in_pix.vld && !cur_eol_q) ? in_pix.mask : cur_mask_q;

    if (!filt_en) begin
      emit        = in_pix.vld;
      emit_mask   = in_pix.mask;
      emit_eof    = in_pix.eof;
      have_cur_d  = 1'b0;
      have_prev_d = 1'b0;
    end else begin
      if (have_cur_q && (in_pix.vld || cur_eol_q)) begin
        emit        = 1'b1;
        emit_mask   = maj3(left_mask, cur_mask_q, right_mask);
        emit_eof    = cur_eof_q;
        have_cur_d  = 1'b0;
        have_prev_d = 1'b0;
      end
      if (in_pix.vld) begin
        have_prev_d = have_cur_q && !cur_eol_q;
        prev_mask_d = cur_mask_q;
        have_cur_d  = 1'b1;
        cur_mask_d  = in_pix.mask;
        cur_eol_d   = in_pix.eol;
        cur_eof_d   = in_pix.eof;
      end
    end

    if (flush) begin
      emit        = 1'b0;
      have_cur_d  = 1'b0;
      have_prev_d = 1'b0;
    end

    o_vld_d  = emit;
    o_mask_d = emit ? emit_mask : o_mask_q;
    o_eof_d  = emit && emit_eof;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      have_cur_q  <= 1'b0;
      cur_mask_q  <= 1'b0;
      cur_eol_q   <= 1'b0;
      cur_eof_q   <= 1'b0;
      have_prev_q <= 1'b0;
      prev_mask_q <= 1'b0;
      o_vld_q     <= 1'b0;
      o_mask_q    <= 1'b0;
      o_eof_q     <= 1'b0;
    end else begin
      have_cur_q  <= have_cur_d;
      cur_mask_q  <= cur_mask_d;
      cur_eol_q   <= cur_eol_d;
      cur_eof_q   <= cur_eof_d;
      have_prev_q <= have_prev_d;
      prev_mask_q <= prev_mask_d;
      o_vld_q     <= o_vld_d;
      o_mask_q    <= o_mask_d;
      o_eof_q     <= o_eof_d;
    end
  end

  assign out_vld  = o_vld_q;
  assign out_mask = o_mask_q;
  assign out_eof  = o_eof_q;

endmodule

// File: rtl/skin_mask_gen.sv
// Cb/Cr skin classifier: double-buffered window bounds, compare stage,
// optional majority filter and per-frame skin-pixel counter.
module skin_mask_gen
  import skin_pkg::*;
#(
  parameter int CW        = 8,
  parameter int OUT_W     = 16,
  parameter int CNT_W     = 20,
  parameter int CB_LO_DEF = DEF_CB_LO,
  parameter int CB_HI_DEF = DEF_CB_HI,
  parameter int CR_LO_DEF = DEF_CR_LO,
  parameter int CR_HI_DEF = DEF_CR_HI
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic             iDVAL,
  input  logic             iSOF,
  input  logic             iEOL,
  input  logic             iEOF,
  input  logic [CW-1:0]    icb,
  input  logic [CW-1:0]    icr,
  input  logic             iCFG_WE,
  input  logic [1:0]       iCFG_ADDR,
  input  logic [CW-1:0]    iCFG_DATA,
  input  logic             iFILT_EN,
  output logic [OUT_W-1:0] oDATA,
  output logic             oMASK,
  output logic             oDVAL,
  output logic [CNT_W-1:0] oSKIN_CNT,
  output logic             oCNT_VLD
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CW-1:0] shadow_q [4];
  logic [CW-1:0] shadow_d [4];
  logic [CW-1:0] active_q [4];
  logic [CW-1:0] active_d [4];
  logic [CW-1:0] bnd [4];
  logic          filt_en_q, filt_en_d;
  logic          locked_q, locked_d;
  logic          in_frame_q, in_frame_d;
  pix_t          s1_q, s1_d;

  logic             sof_acc;
  logic             pix_acc;
  logic             flush;
  logic             cls;
  logic             out_vld;
  logic             out_mask;
  logic             out_eof;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_sum;
  logic [CNT_W-1:0] skin_cnt_q, skin_cnt_d;
  logic             cnt_vld_q, cnt_vld_d;

  // The SOF pixel is judged against the shadow set it is about to commit.
  always_comb begin
    sof_acc = iDVAL && iSOF;
    pix_acc = iDVAL && (locked_q || iSOF);
    flush   = sof_acc && in_frame_q;

    shadow_d = shadow_q;
    if (iCFG_WE) shadow_d[iCFG_ADDR] = iCFG_DATA;

    active_d  = active_q;
    filt_en_d = filt_en_q;
    if (sof_acc) begin
      active_d  = shadow_q;
      filt_en_d = iFILT_EN;
    end

    for (int i = 0; i < 4; i++) bnd[i] = sof_acc ? shadow_q[i] : active_q[i];

    cls = (bnd[ADDR_CB_LO] < icb) && (icb < bnd[ADDR_CB_HI]) &&
          (bnd[ADDR_CR_LO] < icr) && (icr < bnd[ADDR_CR_HI]);
  end

  always_comb begin
    locked_d   = locked_q || sof_acc;
    in_frame_d = in_frame_q;
    if (pix_acc) begin
      if (iSOF)      in_frame_d = !iEOF;
      else if (iEOF) in_frame_d = 1'b0;
    end
    s1_d.vld  = pix_acc;
    s1_d.mask = cls;
    s1_d.eol  = iEOL;
    s1_d.eof  = iEOF;
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      shadow_q[ADDR_CB_LO] <= CW'(CB_LO_DEF);
      shadow_q[ADDR_CB_HI] <= CW'(CB_HI_DEF);
      shadow_q[ADDR_CR_LO] <= CW'(CR_LO_DEF);
      shadow_q[ADDR_CR_HI] <= CW'(CR_HI_DEF);
      active_q[ADDR_CB_LO] <= CW'(CB_LO_DEF);
      active_q[ADDR_CB_HI] <= CW'(CB_HI_DEF);
      active_q[ADDR_CR_LO] <= CW'(CR_LO_DEF);
      active_q[ADDR_CR_HI] <= CW'(CR_HI_DEF);
      filt_en_q  <= 1'b0;
      locked_q   <= 1'b0;
      in_frame_q <= 1'b0;
      s1_q       <= '0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      filt_en_q  <= filt_en_d;
      locked_q   <= locked_d;
      in_frame_q <= in_frame_d;
      s1_q       <= s1_d;
    end
  end

  skin_hmaj3 u_hmaj3 (
    .clk      (iclk),
    .rst      (irst),
    .flush    (flush),
    .filt_en  (filt_en_q),
    .in_pix   (s1_q),
    .out_vld  (out_vld),
    .out_mask (out_mask),
    .out_eof  (out_eof)
  );

  // A restarted frame discards whatever was already tallied.
  always_comb begin
    cnt_d      = cnt_q;
    skin_cnt_d = skin_cnt_q;
    cnt_vld_d  = 1'b0;
    cnt_sum    = cnt_q;
    if (out_vld && out_mask && (cnt_q != CNT_MAX)) cnt_sum = cnt_q + CNT_W'(1);
    if (out_vld) cnt_d = cnt_sum;
    if (out_vld && out_eof) begin
      skin_cnt_d = cnt_sum;
      cnt_vld_d  = 1'b1;
      cnt_d      = '0;
    end
    if (flush) cnt_d = '0;
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      cnt_q      <= '0;
      skin_cnt_q <= '0;
      cnt_vld_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      skin_cnt_q <= skin_cnt_d;
      cnt_vld_q  <= cnt_vld_d;
    end
  end

  assign oDATA     = {OUT_W{out_mask}};
  assign oMASK     = out_mask;
  assign oDVAL     = out_vld;
  assign oSKIN_CNT = skin_cnt_q;
  assign oCNT_VLD  = cnt_vld_q;

endmodule

// File: tb/tb_skin_mask_gen.sv
// Directed bench for skin_mask_gen: bypass, double buffering, filter mode,
// frame counter with saturation, reset and frame relock.
module tb_skin_mask_gen;

  logic        iclk = 1'b0;
  logic        irst;
  logic        iDVAL, iSOF, iEOL, iEOF;
  logic [7:0]  icb, icr;
  logic        iCFG_WE;
  logic [1:0]  iCFG_ADDR;
  logic [7:0]  iCFG_DATA;
  logic        iFILT_EN;
  logic [15:0] oDATA;
  logic        oMASK, oDVAL, oCNT_VLD;
  logic [19:0] oSKIN_CNT;
  logic [15:0] satData;
  logic        satMask, satDval, satCntVld;
  logic [3:0]  satSkinCnt;

  int errors = 0;
  int checks = 0;

  logic [6:0] lineMask = 7'b1001101;
  logic [6:0] lineExp  = 7'b1001111;

  always #5 iclk = ~iclk;

  skin_mask_gen dut (
    .iclk(iclk), .irst(irst), .iDVAL(iDVAL), .iSOF(iSOF), .iEOL(iEOL), .iEOF(iEOF),
    .icb(icb), .icr(icr), .iCFG_WE(iCFG_WE), .iCFG_ADDR(iCFG_ADDR), .iCFG_DATA(iCFG_DATA),
    .iFILT_EN(iFILT_EN), .oDATA(oDATA), .oMASK(oMASK), .oDVAL(oDVAL),
    .oSKIN_CNT(oSKIN_CNT), .oCNT_VLD(oCNT_VLD)
  );

  skin_mask_gen #(.CNT_W(4)) dutSat (
    .iclk(iclk), .irst(irst), .iDVAL(iDVAL), .iSOF(iSOF), .iEOL(iEOL), .iEOF(iEOF),
    .icb(icb), .icr(icr), .iCFG_WE(iCFG_WE), .iCFG_ADDR(iCFG_ADDR), .iCFG_DATA(iCFG_DATA),
    .iFILT_EN(iFILT_EN), .oDATA(satData), .oMASK(satMask), .oDVAL(satDval),
    .oSKIN_CNT(satSkinCnt), .oCNT_VLD(satCntVld)
  );

  task automatic applyStimulus(input logic dval, input logic sof, input logic eol,
                               input logic eof, input logic [7:0] cb, input logic [7:0] cr);
    iDVAL = dval; iSOF = sof; iEOL = eol; iEOF = eof; icb = cb; icr = cr;
    @(posedge iclk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic checkOutput(input string tag, input logic expDval, input logic expMask);
    checks++;
    assert (oDVAL === expDval) else begin
      errors++;
      $error("[TB] FAIL %s oDVAL observed=%0b expected=%0b", tag, oDVAL, expDval);
    end
    if (expDval) begin
      checks++;
      assert ({oMASK, oDATA} === {expMask, {16{expMask}}}) else begin
        errors++;
        $error("[TB] FAIL %s data observed=%0b/%h expected=%0b/%h", tag, oMASK, oDATA,
               expMask, {16{expMask}});
      end
    end
  endtask

  task automatic checkHold(input string tag, input logic expMask);
    checks++;
    assert ({oDVAL, oMASK, oDATA} === {1'b0, expMask, {16{expMask}}}) else begin
      errors++;
      $error("[TB] FAIL %s hold observed=%0b/%0b/%h expected=0/%0b/%h", tag, oDVAL, oMASK,
             oDATA, expMask, {16{expMask}});
    end
  endtask

  task automatic checkCount(input string tag, input logic expVld, input int expCnt);
    checks++;
    assert ({oCNT_VLD, oSKIN_CNT} === {expVld, 20'(expCnt)}) else begin
      errors++;
      $error("[TB] FAIL %s count observed=%0b/%0d expected=%0b/%0d", tag, oCNT_VLD,
             oSKIN_CNT, expVld, expCnt);
    end
  endtask

  task automatic checkSat(input string tag, input int expCnt);
    checks++;
    assert (satSkinCnt === 4'(expCnt)) else begin
      errors++;
      $error("[TB] FAIL %s satcount observed=%0d expected=%0d", tag, satSkinCnt, expCnt);
    end
  endtask

  initial begin
    irst = 1'b1; iFILT_EN = 1'b0;
    iCFG_WE = 1'b0; iCFG_ADDR = 2'd0; iCFG_DATA = 8'd0;
    idle(); idle();
    checkHold("reset_out", 1'b0);
    checkCount("reset_cnt", 1'b0, 0);
    irst = 1'b0;

    // Pixels before the first SOF are ignored
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 8'd100, 8'd140);
      checkOutput("unlocked", 0, 0);
    end
    idle(); checkOutput("unlocked_tail", 0, 0);

    $display("[TB] default bounds, bypass");
    applyStimulus(1, 1, 0, 0, 8'd100, 8'd140); checkOutput("a_lat", 0, 0);
    applyStimulus(1, 0, 0, 0, 8'd85, 8'd140);  checkOutput("a0_100_140", 1, 1);
    applyStimulus(1, 0, 0, 0, 8'd126, 8'd154); checkOutput("a1_cb_eq_lo", 1, 0);
    applyStimulus(1, 0, 1, 1, 8'd127, 8'd140); checkOutput("a2_126_154", 1, 1);
    idle(); checkOutput("a3_cb_eq_hi", 1, 0); checkCount("a_cnt_wait", 0, 0);
    idle(); checkHold("a_hold", 1'b0); checkCount("a_cnt", 1, 2);
    idle(); checkCount("a_cnt_pulse_end", 0, 2);

    $display("[TB] double buffering");
    applyStimulus(1, 1, 0, 0, 8'd100, 8'd140); checkOutput("b_lat", 0, 0);
    iCFG_WE = 1'b1; iCFG_ADDR = 2'd0; iCFG_DATA = 8'd110;
    applyStimulus(1, 0, 0, 0, 8'd100, 8'd140); iCFG_WE = 1'b0; checkOutput("b0", 1, 1);
    applyStimulus(1, 0, 0, 0, 8'd100, 8'd140); checkOutput("b1_shadow_hidden", 1, 1);
    applyStimulus(1, 0, 1, 1, 8'd100, 8'd140); checkOutput("b2_shadow_hidden", 1, 1);
    idle(); checkOutput("b3_shadow_hidden", 1, 1);
    idle(); checkCount("b_cnt", 1, 4);

    iCFG_WE = 1'b1; iCFG_DATA = 8'd85;
    applyStimulus(1, 1, 0, 0, 8'd100, 8'd140); iCFG_WE = 1'b0; checkOutput("c_lat", 0, 0);
    applyStimulus(1, 0, 1, 1, 8'd115, 8'd140); checkOutput("c0_new_bound", 1, 0);
    idle(); checkOutput("c1_new_bound", 1, 1);
    idle(); checkCount("c_cnt", 1, 1);

    applyStimulus(1, 1, 1, 1, 8'd100, 8'd140); checkOutput("d_lat", 0, 0);
    idle(); checkOutput("d0_sof_write_applied", 1, 1);
    idle(); checkCount("d_cnt", 1, 1);

    // CB_LO equal to CB_HI empties the window
    iCFG_WE = 1'b1; iCFG_DATA = 8'd127; idle(); iCFG_WE = 1'b0;
    applyStimulus(1, 1, 1, 1, 8'd126, 8'd140); idle(); checkOutput("l_lo_eq_hi", 1, 0);
    idle(); checkCount("l_cnt", 1, 0);
    iCFG_WE = 1'b1; iCFG_DATA = 8'd85; idle(); iCFG_WE = 1'b0;

    $display("[TB] filter mode");
    iFILT_EN = 1'b1;
    for (int n = 0; n < 7; n++) begin
      applyStimulus(1, n == 0, n == 6, n == 6, lineMask[n] ? 8'd100 : 8'd50,
                    lineMask[n] ? 8'd140 : 8'd50);
      if (n < 2) checkOutput("e_lat", 0, 0);
      else       checkOutput($sformatf("e_px%0d", n - 2), 1, lineExp[n-2]);
    end
    idle(); checkOutput("e_px5", 1, lineExp[5]);
    idle(); checkOutput("e_px6_eol_plus3", 1, lineExp[6]);
    idle(); checkHold("e_hold", 1'b1); checkCount("e_cnt", 1, 5); checkSat("e_sat", 5);
    idle(); checkCount("e_cnt_pulse_end", 0, 5);

    applyStimulus(1, 1, 1, 0, 8'd100, 8'd140); checkOutput("f_lat0", 0, 0);
    idle(); checkOutput("f_lat1", 0, 0);
    applyStimulus(1, 0, 0, 0, 8'd50, 8'd50); checkOutput("f_single_px_line", 1, 1);
    idle(); checkOutput("f_gap", 0, 0);
    applyStimulus(1, 0, 1, 1, 8'd100, 8'd140); checkOutput("f_wait_next", 0, 0);
    idle(); checkOutput("f_line2_px0", 1, 0);
    idle(); checkOutput("f_line2_px1", 1, 1);
    idle(); checkCount("f_cnt", 1, 2);

    $display("[TB] counter");
    iFILT_EN = 1'b0;
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < 8; p++) begin
        applyStimulus(1, (l == 0) && (p == 0), p == 7, (l == 3) && (p == 7),
                      (l * 8 + p < 13) ? 8'd100 : 8'd50, (l * 8 + p < 13) ? 8'd140 : 8'd50);
      end
      idle();
    end
    checkOutput("g_eof_px", 1, 0); checkCount("g_cnt_wait", 0, 2);
    idle(); checkCount("g_cnt", 1, 13); checkSat("g_sat", 13);

    for (int k = 0; k < 20; k++) applyStimulus(1, k == 0, k == 19, k == 19, 8'd100, 8'd140);
    idle(); checkOutput("h_eof_px", 1, 1);
    idle(); checkCount("h_cnt", 1, 20); checkSat("h_sat_clamp", 15);

    $display("[TB] reset and lock");
    applyStimulus(1, 1, 0, 0, 8'd100, 8'd140); checkOutput("i_lat", 0, 0);
    applyStimulus(1, 0, 0, 0, 8'd100, 8'd140); checkOutput("i0", 1, 1);
    irst = 1'b1;
    applyStimulus(1, 0, 0, 0, 8'd100, 8'd140);
    checkHold("i_rst_out", 1'b0); checkCount("i_rst_cnt", 0, 0);
    irst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 8'd100, 8'd140);
      checkOutput("i_relock", 0, 0);
    end
    applyStimulus(1, 1, 1, 1, 8'd100, 8'd140); checkOutput("j_lat", 0, 0);
    idle(); checkOutput("j0", 1, 1);
    idle(); checkCount("j_cnt", 1, 1);

    applyStimulus(1, 1, 0, 0, 8'd100, 8'd140); checkOutput("k_lat", 0, 0);
    applyStimulus(1, 0, 0, 0, 8'd100, 8'd140); checkOutput("k0", 1, 1);
    applyStimulus(1, 0, 0, 0, 8'd100, 8'd140); checkOutput("k1", 1, 1);
    applyStimulus(1, 1, 0, 0, 8'd100, 8'd140); checkOutput("k_restart_drop", 0, 0);
    applyStimulus(1, 0, 1, 1, 8'd50, 8'd50);   checkOutput("k_new0", 1, 1);
    idle(); checkOutput("k_new1", 1, 0);
    idle(); checkCount("k_cnt_restart", 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
